// File: rtl/in_temp_fifo_wp_ctrl_pkg.sv
// Shared definitions for the input temporary FIFO write-side pointer logic.
package in_temp_fifo_wp_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_PKT   = 2'd1,
        OVERFLOW = 2'd2
    } wp_state_t;

endpackage

// File: rtl/in_temp_fifo_ptr_cmp.sv
// Combinational FULL/EMPTY comparator; one slot stays reserved so FULL and EMPTY never alias.
module in_temp_fifo_ptr_cmp #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] wp,
    input  logic [ADDR_W-1:0] commit_wp,
    input  logic [ADDR_W-1:0] rp,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] wp_inc;

    assign wp_inc = wp + ADDR_W'(1);
    assign full   = (wp_inc == rp);
    assign empty  = (commit_wp == rp);

endmodule

// File: rtl/in_temp_fifo_wp_ctrl.sv
// Packet-granular write pointer controller: writes speculatively at WP, publishes at
// COMMIT_WP on pkt_end, and rolls back on overflow or abort.
module in_temp_fifo_wp_ctrl
    import in_temp_fifo_wp_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WP_en,
    input  logic              pkt_start,
    input  logic              pkt_end,
    input  logic              pkt_drop,
    input  logic [ADDR_W-1:0] RP,
    output logic              WE,
    output logic [ADDR_W-1:0] WP,
    output logic [ADDR_W-1:0] COMMIT_WP,
    output logic              FIFO_FULL,
    output logic              FIFO_EMPTY,
    output logic [CNT_W-1:0]  DROP_CNT
);

    wp_state_t         state, state_nx;
    logic [ADDR_W-1:0] wp_q, wp_nx, cwp_q, cwp_nx, base;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W:0]    cnt_sum;
    logic [1:0]        drop_inc;
    logic              we, base_full, restart_full;

    in_temp_fifo_ptr_cmp #(.ADDR_W(ADDR_W)) u_cmp (
        .wp        (wp_q),
        .commit_wp (cwp_q),
        .rp        (RP),
        .full      (FIFO_FULL),
        .empty     (FIFO_EMPTY)
    );

    // A restart mid-packet rewinds to COMMIT_WP, so fullness is judged from there.
    assign restart_full = ((cwp_q + ADDR_W'(1)) == RP);

    always_comb begin
        state_nx  = state;
        wp_nx     = wp_q;
        cwp_nx    = cwp_q;
        we        = 1'b0;
        drop_inc  = 2'd0;
        base      = wp_q;
        base_full = FIFO_FULL;
        if (pkt_drop) begin
            wp_nx    = cwp_q;
            state_nx = IDLE;
            if (state == IN_PKT) drop_inc = 2'd1;
        end else if (WP_en) begin
            if (pkt_start && !(state == OVERFLOW && pkt_end)) begin
                if (state == IN_PKT) begin
                    drop_inc  = 2'd1;
                    base      = cwp_q;
                    base_full = restart_full;
                end
                if (!base_full) begin
                    we    = 1'b1;
                    wp_nx = base + ADDR_W'(1);
                    if (pkt_end) begin
                        cwp_nx   = base + ADDR_W'(1);
                        state_nx = IDLE;
                    end else begin
                        state_nx = IN_PKT;
                    end
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    wp_nx    = base;
                    state_nx = pkt_end ? IDLE : OVERFLOW;
                end
            end else if (state == IN_PKT) begin
                if (!FIFO_FULL) begin
                    we    = 1'b1;
                    wp_nx = wp_q + ADDR_W'(1);
                    if (pkt_end) begin
                        cwp_nx   = wp_q + ADDR_W'(1);
                        state_nx = IDLE;
                    end
                end else begin
                    drop_inc = 2'd1;
                    wp_nx    = cwp_q;
                    state_nx = pkt_end ? IDLE : OVERFLOW;
                end
            end else if (state == OVERFLOW && pkt_end) begin
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wp_q  <= '0;
            cwp_q <= '0;
        end else begin
            state <= state_nx;
            wp_q  <= wp_nx;
            cwp_q <= cwp_nx;
        end
    end

    assign cnt_sum = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              drop_cnt_q <= '0;
        else if (cnt_sum[CNT_W]) drop_cnt_q <= '1;
        else                   drop_cnt_q <= cnt_sum[CNT_W-1:0];
    end

    assign WE        = we;
    assign WP        = wp_q;
    assign COMMIT_WP = cwp_q;
    assign DROP_CNT  = drop_cnt_q;

endmodule

// File: tb/tb_in_temp_fifo_wp_ctrl.sv
// Directed bench for in_temp_fifo_wp_ctrl with a packet-level reference model.
module tb_in_temp_fifo_wp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       WP_en = 1'b0, pkt_start = 1'b0, pkt_end = 1'b0, pkt_drop = 1'b0;
    logic [7:0] RP = 8'd0;
    logic       WE, FIFO_FULL, FIFO_EMPTY;
    logic [7:0] WP, COMMIT_WP, DROP_CNT;

    int total = 0;
    int bad   = 0;

    // Model: pointers as plain integers, packet status as two flags.
    int m_wp, m_cwp, m_cnt, n_wp, n_cwp, n_cnt;
    bit m_open, m_lost, n_open, n_lost, exp_we;
    int addr_q[$];

    in_temp_fifo_wp_ctrl #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .WP_en      (WP_en),
        .pkt_start  (pkt_start),
        .pkt_end    (pkt_end),
        .pkt_drop   (pkt_drop),
        .RP         (RP),
        .WE         (WE),
        .WP         (WP),
        .COMMIT_WP  (COMMIT_WP),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_EMPTY (FIFO_EMPTY),
        .DROP_CNT   (DROP_CNT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wp = 0; m_cwp = 0; m_cnt = 0; m_open = 0; m_lost = 0;
    endtask

    function automatic bit is_full(input int p);
        return ((p + 1) % 256) == int'(RP);
    endfunction

    task automatic model_eval(input bit en, input bit s, input bit e, input bit d);
        int drops, base;
        drops = 0;
        n_wp = m_wp; n_cwp = m_cwp; n_open = m_open; n_lost = m_lost;
        exp_we = 0;
        if (d) begin
            if (m_open) drops = 1;
            n_wp = m_cwp; n_open = 0; n_lost = 0;
        end else if (en) begin
            if (s && !(m_lost && e)) begin
                if (m_open) drops = 1;
                base = m_open ? m_cwp : m_wp;
                if (!is_full(base)) begin
                    exp_we = 1;
                    n_wp = (base + 1) % 256;
                    if (e) n_cwp = n_wp;
                    n_open = !e; n_lost = 0;
                end else begin
                    drops++;
                    n_wp = base; n_open = 0; n_lost = !e;
                end
            end else if (m_open) begin
                if (!is_full(m_wp)) begin
                    exp_we = 1;
                    n_wp = (m_wp + 1) % 256;
                    if (e) begin n_cwp = n_wp; n_open = 0; end
                end else begin
                    drops = 1;
                    n_wp = m_cwp; n_open = 0; n_lost = !e;
                end
            end else if (m_lost && e) begin
                n_lost = 0;
            end
        end
        n_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
    endtask

    task automatic check_outputs();
        chk("WE", int'(WE), int'(exp_we));
        chk("WP", int'(WP), m_wp);
        chk("COMMIT_WP", int'(COMMIT_WP), m_cwp);
        chk("FIFO_FULL", int'(FIFO_FULL), int'(is_full(m_wp)));
        chk("FIFO_EMPTY", int'(FIFO_EMPTY), int'(m_cwp == int'(RP)));
        chk("DROP_CNT", int'(DROP_CNT), m_cnt);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit en, input bit s, input bit e, input bit d);
        WP_en = en; pkt_start = s; pkt_end = e; pkt_drop = d;
        #2;
        model_eval(en, s, e, d);
        check_outputs();
        if (WE) addr_q.push_back(int'(WP));
        @(posedge clk);
        #1;
        m_wp = n_wp; m_cwp = n_cwp; m_cnt = n_cnt; m_open = n_open; m_lost = n_lost;
        @(negedge clk);
    endtask

    task automatic do_reset();
        WP_en = 0; pkt_start = 0; pkt_end = 0; pkt_drop = 0;
        rst = 0;
        #2;
        rst = 1;
        model_reset();
        addr_q.delete();
        @(negedge clk);
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++)
            cycle(1'b1, i == 0, i == len - 1, 1'b0);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_WP", int'(WP), 0);
        chk("rst_COMMIT_WP", int'(COMMIT_WP), 0);
        chk("rst_EMPTY", int'(FIFO_EMPTY), 1);
        chk("rst_FULL", int'(FIFO_FULL), 0);
        chk("rst_WE", int'(WE), 0);
        chk("rst_DROP_CNT", int'(DROP_CNT), 0);
        #1 rst = 1;
        @(negedge clk);

        // 4-word packet
        send_pkt(4);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("p4_we_cycles", addr_q.size(), 4);
        chk("p4_WP", int'(WP), 4);
        chk("p4_COMMIT_WP", int'(COMMIT_WP), 4);
        chk("p4_EMPTY", int'(FIFO_EMPTY), 0);

        // 3 words then abort
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_WP", int'(WP), 0);
        chk("drop_COMMIT_WP", int'(COMMIT_WP), 0);
        chk("drop_EMPTY", int'(FIFO_EMPTY), 1);
        chk("drop_DROP_CNT", int'(DROP_CNT), 1);

        // 300-word packet overflows a 255-word FIFO
        do_reset();
        send_pkt(300);
        chk("ovf_we_cycles", addr_q.size(), 255);
        chk("ovf_WP", int'(WP), 0);
        chk("ovf_COMMIT_WP", int'(COMMIT_WP), 0);
        chk("ovf_DROP_CNT", int'(DROP_CNT), 1);

        // Pointer wrap from 250
        do_reset();
        send_pkt(250);
        RP = 8'd250;
        addr_q.delete();
        send_pkt(10);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_WP", int'(WP), 4);
        chk("wrap_COMMIT_WP", int'(COMMIT_WP), 4);
        chk("wrap_count", addr_q.size(), 10);
        if (addr_q.size() == 10) begin
            chk("wrap_addr0", addr_q[0], 250);
            chk("wrap_addr5", addr_q[5], 255);
            chk("wrap_addr6", addr_q[6], 0);
            chk("wrap_addr9", addr_q[9], 3);
            for (int i = 0; i < 10; i++) chk("wrap_addr", addr_q[i], (250 + i) % 256);
        end
        RP = 8'd0;

        // Single-word packet, then a packet restarted mid-way
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("single_COMMIT_WP", int'(COMMIT_WP), 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_pre_WP", int'(WP), 3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("restart_WP", int'(WP), 2);
        chk("restart_COMMIT_WP", int'(COMMIT_WP), 1);
        chk("restart_DROP_CNT", int'(DROP_CNT), 1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("restart_end_COMMIT_WP", int'(COMMIT_WP), 3);

        // Asynchronous reset between edges mid-packet
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("async_pre_WP", int'(WP), 2);
        WP_en = 1; pkt_start = 0; pkt_end = 0; pkt_drop = 0;
        #2 rst = 0;
        #1;
        chk("async_WP", int'(WP), 0);
        chk("async_COMMIT_WP", int'(COMMIT_WP), 0);
        chk("async_EMPTY", int'(FIFO_EMPTY), 1);
        chk("async_FULL", int'(FIFO_FULL), 0);
        chk("async_WE", int'(WE), 0);
        chk("async_DROP_CNT", int'(DROP_CNT), 0);
        rst = 1;
        model_reset();
        WP_en = 0;
        addr_q.delete();
        @(negedge clk);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("async_next_count", addr_q.size(), 1);
        if (addr_q.size() == 1) chk("async_next_addr", addr_q[0], 0);
        chk("async_next_COMMIT_WP", int'(COMMIT_WP), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/in_temp_fifo_wp_ctrl.md
# in_temp_fifo_wp_ctrl

Write-side pointer controller for the input temporary FIFO. It pairs with the read-pointer logic on the same 2^ADDR_W-entry dual-port memory, and generates the write address and qualified write enable for that memory. It works in whole packets: a packet becomes visible to the read side only when its last word is written. A packet that overflows the FIFO, or that upstream aborts, is rolled back. The block also produces FIFO_EMPTY and FIFO_FULL by comparing its pointers against the read pointer RP.

## Interface
- ADDR_W, 8, pointer/address width; FIFO depth 2^ADDR_W, usable capacity 2^ADDR_W-1 words (one slot reserved)
- CNT_W, 8, width of drop counter
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- WP_en  in  1  upstream offers one data word this cycle
- pkt_start  in  1  qualifies the current WP_en word as the first word of a packet
- pkt_end  in  1  qualifies the current WP_en word as the last word of a packet
- pkt_drop  in  1  upstream aborts the packet in progress; may be asserted without WP_en
- RP  in  ADDR_W  current read pointer from the read side
- WE  out  1  memory write enable (combinational)
- WP  out  ADDR_W  memory write address; working pointer (registered)
- COMMIT_WP  out  ADDR_W  end of last committed packet (registered)
- FIFO_FULL  out  1  combinational: (WP+1) mod 2^ADDR_W == RP
- FIFO_EMPTY  out  1  combinational: COMMIT_WP == RP
- DROP_CNT  out  CNT_W  packets discarded (overflow or abort); saturates at all-ones

## Operation
- States: IDLE (no packet open), IN_PKT (packet being written), OVERFLOW (packet lost, discarding its remaining words).
- IDLE:
  - WP_en without pkt_start is ignored (WE=0).
  - WP_en&pkt_start with FIFO_FULL=0: WE=1, WP<=WP+1. With pkt_end also set, COMMIT_WP<=WP+1 and the state stays IDLE; otherwise go to IN_PKT.
  - WP_en&pkt_start with FIFO_FULL=1: WE=0, DROP_CNT+1. Go to OVERFLOW unless pkt_end is also set.
- IN_PKT:
  - WP_en with FIFO_FULL=0: WE=1, WP<=WP+1. With pkt_end, COMMIT_WP<=WP+1 and go to IDLE.
  - WP_en with FIFO_FULL=1: WE=0, WP<=COMMIT_WP, DROP_CNT+1. Go to IDLE if pkt_end, else OVERFLOW.
  - pkt_start (with WP_en) while IN_PKT: the open packet is abandoned. DROP_CNT+1, and the word is written at address COMMIT_WP with WP<=COMMIT_WP+1. It is handled as a fresh start, including pkt_end handling.
- OVERFLOW: WE=0 always. WP_en&pkt_end goes to IDLE. WP_en&pkt_start&~pkt_end handles the word as a fresh start from IDLE.
- pkt_drop has highest priority in every state:
  - WE=0 and WP<=COMMIT_WP.
  - DROP_CNT+1 only if the state is IN_PKT; the OVERFLOW drop has already been counted.
  - Next state is IDLE.
- Pointer arithmetic is modulo 2^ADDR_W; wrap from all-ones to 0 is silent.
- Nothing here ever changes RP. Committed data is never overwritten, because FULL is evaluated against the working WP.

## Timing
- Reset (rst=0), asynchronous: WP=0, COMMIT_WP=0, DROP_CNT=0, state IDLE. Outputs then read FIFO_EMPTY=1, FIFO_FULL=0 (RP=0 after read-side reset), WE=0.
- WE and the data address WP are valid in the same cycle as WP_en; memory latches on that rising edge.
- Commit latency: FIFO_EMPTY deasserts in the cycle after the pkt_end write edge, i.e. one cycle after the last word.
- FULL/EMPTY follow RP combinationally. An RP advance takes effect in the same cycle.
- An accepted write and an RP advance in the same cycle are both legal; FULL uses the pre-edge WP and RP.

## Structure
- Shared package: state encoding constants (IDLE=2'd0, IN_PKT=2'd1, OVERFLOW=2'd2) and the default ADDR_W.
- Sub-module: in_temp_fifo_ptr_cmp, combinational FULL/EMPTY comparator. It is reusable by the read-side logic.
- Everything else is a single always block for the state and pointers, plus a saturating counter.

## Test plan
- Reset, then a 4-word packet (start on word 0, end on word 3), RP=0 -> WE high 4 cycles, WP=4, COMMIT_WP=4, FIFO_EMPTY=0 one cycle after the last word.
- 3 words then pkt_drop -> WP returns to 0, COMMIT_WP=0, FIFO_EMPTY stays 1, DROP_CNT=1.
- RP=0, write a 300-word packet -> WE stops at WP=255 with FIFO_FULL=1, state OVERFLOW, remaining words ignored. At pkt_end WP=0, DROP_CNT=1.
- Wrap: RP=250, COMMIT_WP=WP=250, then a 10-word packet -> WP=4, COMMIT_WP=4; the addresses written are 250..255, 0..3.
- Single-word packet (start&end same cycle) followed by pkt_start mid-packet -> the first commits (COMMIT_WP=1). The second is abandoned, DROP_CNT=1, and the new packet starts at address 1.
- rst pulsed low mid-packet, asynchronously between edges -> all outputs go to reset values immediately and the next packet starts at address 0.
